// File: rtl/meas_scheduler.sv
// rtl/meas_scheduler.sv - periodic measurement scheduler with trigger-level control and publish handshake
// Samples quasi-static foreign-domain results twice per attempt and publishes them once per interval.
module meas_scheduler #(
  parameter int unsigned MEAS_PERIOD = 25_000_000,
  parameter logic [7:0]  TRIG_HYST   = 8'd2,
  parameter logic [7:0]  MIN_VPP     = 8'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        auto_en,
  input  logic [7:0]  man_level,
  input  logic [19:0] ad_freq,
  input  logic [7:0]  ad_vpp,
  input  logic [7:0]  ad_max,
  input  logic [7:0]  ad_min,
  output logic [7:0]  trig_level,
  output logic [19:0] res_freq,
  output logic [7:0]  res_vpp,
  output logic [7:0]  res_max,
  output logic [7:0]  res_min,
  output logic        res_valid,
  input  logic        res_ack,
  output logic        no_signal,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SAMPLE, S_CALC, S_PUBLISH} state_t;

  localparam logic [25:0] LAST_CNT = 26'(MEAS_PERIOD - 1);

  state_t      state, state_nxt;
  logic [25:0] cnt;
  logic        phase;
  logic [1:0]  attempt;
  logic [19:0] samp_freq;
  logic [7:0]  samp_vpp, samp_max, samp_min;
  logic [7:0]  lvl;
  logic        nosig;
  logic        discard;
  logic        match, sample_done, pub_step, lvl_update, do_pub;
  logic [8:0]  lvl_sum;
  logic [7:0]  lvl_diff;

  assign match = (ad_freq == samp_freq) && (ad_vpp == samp_vpp) &&
                 (ad_max == samp_max) && (ad_min == samp_min);
  // Second cycle of an attempt: accept on agreement, or unconditionally on the 4th try.
  assign sample_done = phase && (match || attempt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!run) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_WAIT;
        S_WAIT:    if (cnt == LAST_CNT) state_nxt = S_SAMPLE;
        S_SAMPLE:  if (sample_done) state_nxt = S_CALC;
        S_CALC:    state_nxt = S_PUBLISH;
        S_PUBLISH: state_nxt = S_WAIT;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != S_IDLE);
    pub_step = (state == S_PUBLISH) && run;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (state == S_WAIT) cnt <= cnt + 26'd1;
    else                      cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= 1'b0;
      attempt   <= 2'd0;
      samp_freq <= '0;
      samp_vpp  <= '0;
      samp_max  <= '0;
      samp_min  <= '0;
    end else if (state == S_SAMPLE) begin
      phase     <= ~phase;
      samp_freq <= ad_freq;
      samp_vpp  <= ad_vpp;
      samp_max  <= ad_max;
      samp_min  <= ad_min;
      if (phase && !match) attempt <= attempt + 2'd1;
    end else begin
      phase   <= 1'b0;
      attempt <= 2'd0;
    end
  end

  assign lvl_sum = {1'b0, samp_max} + {1'b0, samp_min};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl   <= 8'd0;
      nosig <= 1'b0;
    end else if (state == S_CALC) begin
      lvl   <= 8'(lvl_sum >> 1);
      nosig <= (samp_vpp < MIN_VPP);
    end
  end

  assign lvl_diff   = (lvl >= trig_level) ? (lvl - trig_level) : (trig_level - lvl);
  assign lvl_update = auto_en && !nosig && (lvl_diff >= TRIG_HYST);
  // An auto level change invalidates the interval just measured at the old level.
  assign do_pub     = pub_step && !discard && !lvl_update;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     trig_level <= 8'd128;
    else if (!auto_en)              trig_level <= man_level;
    else if (pub_step && lvl_update) trig_level <= lvl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  discard <= 1'b1;
    else if (!auto_en && man_level != trig_level) discard <= 1'b1;
    else if (pub_step)                           discard <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_freq  <= '0;
      res_vpp   <= '0;
      res_max   <= '0;
      res_min   <= '0;
      no_signal <= 1'b0;
    end else if (do_pub) begin
      res_freq  <= nosig ? 20'd0 : samp_freq;
      res_vpp   <= samp_vpp;
      res_max   <= samp_max;
      res_min   <= samp_min;
      no_signal <= nosig;
    end
  end

  // A publish wins over a simultaneous ack; an ack in that cycle still rules out overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (do_pub) begin
      res_valid <= 1'b1;
      overrun   <= res_valid & ~res_ack;
    end else if (res_valid && res_ack) begin
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule
